// File: rtl/peripheral_syn_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_syn_pkg
// Shared definitions for the commit-synchronisation peripheral:
//   - default commit-FIFO depth
//   - field widths of a retired-instruction record
//   - bit layout of the packed dutpc word
//   - FSM state encoding of the publisher
//   - the FIFO entry type and a helper that packs dutpc from an entry
// ---------------------------------------------------------------------------
package peripheral_syn_pkg;

    // Commit FIFO depth (power of two, 2..64)
    localparam int DEPTH_DEFAULT = 8;

    // Record field widths
    localparam int PC_W     = 64;
    localparam int RFDEST_W = 5;
    localparam int DATA_W   = 64;
    localparam int SEQ_W    = 64;
    localparam int DUTPC_W  = 64;

    // dutpc layout: [63] rfwen, [62:61] zero pad, [60:56] rfdest, [55:0] pc[55:0]
    localparam int DUTPC_WEN_BIT = 63;
    localparam int DUTPC_PAD_HI  = 62;
    localparam int DUTPC_PAD_LO  = 61;
    localparam int DUTPC_DEST_HI = 60;
    localparam int DUTPC_DEST_LO = 56;
    localparam int DUTPC_PC_HI   = 55;

    // Publisher FSM encoding
    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_PUBLISH  = 2'b01;
    localparam logic [1:0] ST_WAIT_ACK = 2'b10;

    // One retired instruction as held in the commit FIFO
    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [RFDEST_W-1:0] rfdest;
        logic                rfwen;
        logic [DATA_W-1:0]   rfdata;
        logic [SEQ_W-1:0]    seq;
    } commit_entry_t;

    // Build the host-visible dutpc word from an entry. Only pc[55:0] fits;
    // the upper pc bits are intentionally discarded.
    function automatic logic [DUTPC_W-1:0] pack_dutpc(input commit_entry_t e);
        logic [DUTPC_W-1:0] word;
        word[DUTPC_WEN_BIT]                 = e.rfwen;
        word[DUTPC_PAD_HI:DUTPC_PAD_LO]     = 2'b00;
        word[DUTPC_DEST_HI:DUTPC_DEST_LO]   = e.rfdest;
        word[DUTPC_PC_HI:0]                 = e.pc[DUTPC_PC_HI:0];
        return word;
    endfunction

endpackage

// File: rtl/syn_commit_fifo.sv
// ---------------------------------------------------------------------------
// syn_commit_fifo
// Synchronous FIFO holding retired-instruction records until the publisher
// takes them. Head entry is presented combinationally so the consumer can
// register it on the same edge that pops it.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (empties FIFO, ptrs to 0)
//   push_i       in   write push_data_i at the tail on this edge
//   push_data_i  in   record to write
//   pop_i        in   advance the head on this edge
//   head_o       out  record at the head (valid when count_o != 0)
//   count_o      out  occupancy, 0..DEPTH
//
// The caller guarantees push_i is never asserted when full and pop_i is never
// asserted when empty; push and pop on the same edge both take effect.
// ---------------------------------------------------------------------------
module syn_commit_fifo
    import peripheral_syn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  commit_entry_t push_data_i,
    input  logic          pop_i,
    output commit_entry_t head_o,
    output logic [CW-1:0] count_o
);

    // Storage: no reset needed, occupancy tracking makes stale data invisible
    commit_entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Pointers are exactly log2(DEPTH) bits wide, so the natural binary
    // roll-over implements the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !reset) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/peripheral_syn_ctrl.sv
// ---------------------------------------------------------------------------
// peripheral_syn_ctrl
// Captures retired instructions from the DUT core into a commit FIFO, tags
// each with a 64-bit sequence number, and publishes them one at a time to a
// host through registered outputs with a one-cycle capture strobe, waiting
// for a host acknowledge before publishing the next one.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   commit_valid     in   core retired one instruction this cycle
//   commit_pc        in   retired PC (64)
//   commit_rfdest    in   destination register index (5)
//   commit_rfwen     in   register-file write enable
//   commit_rfdata    in   write-back data (64)
//   commit_ready     out  FIFO not full (and not in reset)
//   host_ack         in   host consumed the published record
//   dutpc            out  {rfwen, 2'b00, rfdest, pc[55:0]}
//   rfData           out  published write-back data
//   instrcnt         out  sequence number of the published record
//   syn_reg1_update  out  one-cycle strobe: dutpc/instrcnt valid
//   sync_valid       out  one-cycle strobe: rfData valid
//   fifo_count       out  FIFO occupancy
//   overflow         out  sticky: a commit was dropped because FIFO was full
// ---------------------------------------------------------------------------
module peripheral_syn_ctrl
    import peripheral_syn_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                commit_valid,
    input  logic [PC_W-1:0]     commit_pc,
    input  logic [RFDEST_W-1:0] commit_rfdest,
    input  logic                commit_rfwen,
    input  logic [DATA_W-1:0]   commit_rfdata,
    output logic                commit_ready,
    input  logic                host_ack,
    output logic [DUTPC_W-1:0]  dutpc,
    output logic [DATA_W-1:0]   rfData,
    output logic [SEQ_W-1:0]    instrcnt,
    output logic                syn_reg1_update,
    output logic                sync_valid,
    output logic [CW-1:0]       fifo_count,
    output logic                overflow
);

    // -----------------------------------------------------------------------
    // Internal state
    // -----------------------------------------------------------------------
    logic [STATE_W-1:0] state_q,      state_d;
    logic [SEQ_W-1:0]   accept_cnt_q, accept_cnt_d;
    logic               overflow_q,   overflow_d;
    logic               strobe_q,     strobe_d;
    logic [DUTPC_W-1:0] dutpc_q,      dutpc_d;
    logic [DATA_W-1:0]  rfdata_q,     rfdata_d;
    logic [SEQ_W-1:0]   instrcnt_q,   instrcnt_d;

    commit_entry_t      push_entry;
    commit_entry_t      head_entry;
    logic               push;
    logic               pop;
    logic [CW-1:0]      count;

    // pc[63:56] travels through the FIFO but is not part of dutpc
    logic               unused_pc_hi;
    assign unused_pc_hi = ^head_entry.pc[PC_W-1:DUTPC_PC_HI+1];

    // -----------------------------------------------------------------------
    // Commit acceptance
    // -----------------------------------------------------------------------
    // Ready depends only on the registered count, so a pop on the same edge
    // cannot make room for a push when the FIFO is full.
    assign commit_ready = !reset && (count != CW'(DEPTH));
    assign push         = commit_valid && commit_ready;

    // The sequence number is the accept counter value before this commit
    assign push_entry.pc     = commit_pc;
    assign push_entry.rfdest = commit_rfdest;
    assign push_entry.rfwen  = commit_rfwen;
    assign push_entry.rfdata = commit_rfdata;
    assign push_entry.seq    = accept_cnt_q;

    // The publisher only takes a record when it is idle
    assign pop = !reset && (state_q == ST_IDLE) && (count != '0);

    syn_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (count)
    );

    // -----------------------------------------------------------------------
    // Counter, overflow and publisher FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        accept_cnt_d = accept_cnt_q;
        overflow_d   = overflow_q;
        strobe_d     = strobe_q;
        dutpc_d      = dutpc_q;
        rfdata_d     = rfdata_q;
        instrcnt_d   = instrcnt_q;

        // Counter wraps naturally from all-ones to zero
        if (push) begin
            accept_cnt_d = accept_cnt_q + SEQ_W'(1);
        end
        if (commit_valid && !commit_ready) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                strobe_d = 1'b0;
                if (pop) begin
                    dutpc_d    = pack_dutpc(head_entry);
                    rfdata_d   = head_entry.rfdata;
                    instrcnt_d = head_entry.seq;
                    strobe_d   = 1'b1;
                    state_d    = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                // Strobe lasts exactly the PUBLISH cycle; ack is ignored here
                strobe_d = 1'b0;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                strobe_d = 1'b0;
                if (host_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                strobe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            accept_cnt_q <= '0;
            overflow_q   <= 1'b0;
            strobe_q     <= 1'b0;
            dutpc_q      <= '0;
            rfdata_q     <= '0;
            instrcnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            accept_cnt_q <= accept_cnt_d;
            overflow_q   <= overflow_d;
            strobe_q     <= strobe_d;
            dutpc_q      <= dutpc_d;
            rfdata_q     <= rfdata_d;
            instrcnt_q   <= instrcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Both strobes come from one register so they can never disagree
    assign syn_reg1_update = strobe_q;
    assign sync_valid      = strobe_q;
    assign dutpc           = dutpc_q;
    assign rfData          = rfdata_q;
    assign instrcnt        = instrcnt_q;
    assign fifo_count      = count;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_peripheral_syn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_peripheral_syn_ctrl
// Directed and random stimulus against a queue-based reference model of the
// commit synchroniser. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_peripheral_syn_ctrl;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          commit_valid;
    logic [63:0]   commit_pc;
    logic [4:0]    commit_rfdest;
    logic          commit_rfwen;
    logic [63:0]   commit_rfdata;
    logic          commit_ready;
    logic          host_ack;
    logic [63:0]   dutpc;
    logic [63:0]   rfData;
    logic [63:0]   instrcnt;
    logic          syn_reg1_update;
    logic          sync_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    always #5 clk = ~clk;

    peripheral_syn_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_rfdest   (commit_rfdest),
        .commit_rfwen    (commit_rfwen),
        .commit_rfdata   (commit_rfdata),
        .commit_ready    (commit_ready),
        .host_ack        (host_ack),
        .dutpc           (dutpc),
        .rfData          (rfData),
        .instrcnt        (instrcnt),
        .syn_reg1_update (syn_reg1_update),
        .sync_valid      (sync_valid),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [4:0]  dest;
        logic        wen;
        logic [63:0] data;
        logic [63:0] seq;
    } rec_t;

    rec_t        fifo_m[$];     // records accepted but not yet published
    rec_t        cur_m;         // record currently shown to the host
    logic [63:0] cnt_m;         // next sequence number
    bit          ovf_m;
    bit          strobe_m;
    int          pub_age;       // -1: publisher free; 0: strobe cycle; 1: waiting for ack

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic [63:0] pub_log[$];
    int          pub_cyc[$];

    function automatic rec_t zero_rec();
        rec_t r;
        r.pc = '0; r.dest = '0; r.wen = 1'b0; r.data = '0; r.seq = '0;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc   = {$urandom, $urandom};
        r.dest = 5'($urandom);
        r.wen  = 1'($urandom);
        r.data = {$urandom, $urandom};
        r.seq  = '0;
        return r;
    endfunction

    function automatic logic [63:0] dutpc_of(input rec_t r);
        return {r.wen, 2'b00, r.dest, r.pc[55:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then
    // compare every output on the following falling edge.
    task automatic step(input bit rst, input bit cv, input bit ack, input rec_t r);
        bit   acc;
        bit   pub;
        rec_t e;
        reset         = rst;
        commit_valid  = cv;
        commit_pc     = r.pc;
        commit_rfdest = r.dest;
        commit_rfwen  = r.wen;
        commit_rfdata = r.data;
        host_ack      = ack;
        #1;
        chk("commit_ready", 64'(commit_ready), 64'(!rst && (fifo_m.size() != DEPTH)));
        pub = 1'b0;
        if (rst) begin
            fifo_m.delete();
            cur_m   = zero_rec();
            cnt_m   = '0;
            ovf_m   = 1'b0;
            pub_age = -1;
        end else begin
            acc = cv && (fifo_m.size() != DEPTH);
            if (cv && !acc) ovf_m = 1'b1;
            if (pub_age < 0) begin
                if (fifo_m.size() > 0) begin
                    cur_m   = fifo_m.pop_front();
                    pub     = 1'b1;
                    pub_age = 0;
                end
            end else if (pub_age == 0) begin
                pub_age = 1;
            end else if (ack) begin
                pub_age = -1;
            end
            if (acc) begin
                e     = r;
                e.seq = cnt_m;
                fifo_m.push_back(e);
                cnt_m = cnt_m + 64'd1;
            end
        end
        strobe_m = pub;
        @(posedge clk);
        @(negedge clk);
        cycle++;
        chk("syn_reg1_update", 64'(syn_reg1_update), 64'(strobe_m));
        chk("sync_valid",      64'(sync_valid),      64'(strobe_m));
        chk("dutpc",           dutpc,                dutpc_of(cur_m));
        chk("rfData",          rfData,               cur_m.data);
        chk("instrcnt",        instrcnt,             cur_m.seq);
        chk("fifo_count",      64'(fifo_count),      64'(fifo_m.size()));
        chk("overflow",        64'(overflow),        64'(ovf_m));
        if (syn_reg1_update === 1'b1) begin
            pub_log.push_back(instrcnt);
            pub_cyc.push_back(cycle);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rec_t z;
        rec_t r35;
        z = zero_rec();
        reset = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_rfdest = '0;
        commit_rfwen = 1'b0; commit_rfdata = '0; host_ack = 1'b0;
        cur_m = z; cnt_m = '0; ovf_m = 1'b0; strobe_m = 1'b0; pub_age = -1;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, z);
        step(1, 1, 0, rnd_rec());   // commit during reset is not accepted
        chk("reset_dutpc", dutpc, 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);

        // Single commit: strobes two cycles after acceptance
        r35 = z;
        r35.pc = 64'h8000_0000; r35.dest = 5'd5; r35.wen = 1'b1; r35.data = 64'hDEAD_BEEF;
        step(0, 1, 0, r35);
        chk("single_early_strobe", 64'(syn_reg1_update), 64'd0);
        step(0, 0, 0, z);
        chk("single_strobe",   64'(syn_reg1_update), 64'd1);
        chk("single_dutpc",    dutpc,    64'h8500_0000_8000_0000);
        chk("single_rfData",   rfData,   64'hDEAD_BEEF);
        chk("single_instrcnt", instrcnt, 64'd0);
        step(0, 0, 1, z);           // ack in PUBLISH is ignored
        step(0, 0, 0, z);
        step(0, 0, 1, z);

        // Burst of 10 with no ack
        step(1, 0, 0, z);
        pub_log.delete(); pub_cyc.delete();
        for (int i = 0; i < 10; i++) step(0, 1, 0, rnd_rec());
        chk("burst_overflow", 64'(overflow),     64'd1);
        chk("burst_count",    64'(fifo_count),   64'(DEPTH));
        chk("burst_ready",    64'(commit_ready), 64'd0);
        for (int i = 0; i < 40; i++) step(0, 0, 1, z);
        chk("burst_pub_total", 64'(pub_log.size()), 64'd9);
        for (int i = 0; i < pub_log.size(); i++) chk("burst_order", pub_log[i], 64'(i));

        // Continuous commits with ack held high
        step(1, 0, 0, z);
        pub_log.delete(); pub_cyc.delete();
        for (int i = 0; i < 40; i++) step(0, 1, 1, rnd_rec());
        chk("stream_pub_min", 64'(pub_log.size() >= 10), 64'd1);
        for (int i = 1; i < pub_log.size(); i++) begin
            chk("stream_seq_inc", pub_log[i], pub_log[i-1] + 64'd1);
            chk("stream_period",  64'(pub_cyc[i] - pub_cyc[i-1]), 64'd3);
        end

        // Push and pop on the same edge at occupancy 3
        step(1, 0, 0, z);
        for (int i = 0; i < 4; i++) step(0, 1, 0, rnd_rec());
        chk("pp_pre_count", 64'(fifo_count), 64'd3);
        step(0, 0, 1, z);
        step(0, 1, 0, rnd_rec());
        chk("pp_count",  64'(fifo_count),      64'd3);
        chk("pp_strobe", 64'(syn_reg1_update), 64'd1);

        // Reset while waiting for ack with 4 queued
        step(1, 0, 0, z);
        for (int i = 0; i < 5; i++) step(0, 1, 0, rnd_rec());
        step(0, 0, 0, z);
        chk("mid_pre_count", 64'(fifo_count), 64'd4);
        step(1, 0, 0, z);
        chk("mid_dutpc",    dutpc,                 64'd0);
        chk("mid_rfData",   rfData,                64'd0);
        chk("mid_instrcnt", instrcnt,              64'd0);
        chk("mid_strobe",   64'(sync_valid),       64'd0);
        chk("mid_count",    64'(fifo_count),       64'd0);
        step(0, 1, 0, rnd_rec());
        step(0, 0, 0, z);
        chk("mid_next_strobe",   64'(syn_reg1_update), 64'd1);
        chk("mid_next_instrcnt", instrcnt,             64'd0);
        step(0, 0, 1, z);
        step(0, 0, 1, z);

        // Accept counter wrap
        dut.accept_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt_m            = 64'hFFFF_FFFF_FFFF_FFFF;
        pub_log.delete(); pub_cyc.delete();
        step(0, 1, 1, rnd_rec());
        step(0, 1, 1, rnd_rec());
        for (int i = 0; i < 8; i++) step(0, 0, 1, z);
        chk("wrap_pub_total", 64'(pub_log.size()), 64'd2);
        if (pub_log.size() == 2) begin
            chk("wrap_first",  pub_log[0], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("wrap_second", pub_log[1], 64'd0);
        end

        // Random traffic
        step(1, 0, 0, z);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 1) == 1, rnd_rec());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
